// File: rtl/wb_ctrl_pkg.sv
// wb_ctrl_pkg -- shared constants, state encoding and source-code helpers
// for the writeback controller (wb_ctrl) and its optional timeout counter.
package wb_ctrl_pkg;

    localparam int SRC_W  = 3;
    localparam int DEST_W = 5;

    // Writeback source codes as presented on ReqSrc and echoed on WriteData.
    localparam logic [SRC_W-1:0] SRC_ULA   = 3'b000;
    localparam logic [SRC_W-1:0] SRC_LS    = 3'b001;
    localparam logic [SRC_W-1:0] SRC_HI    = 3'b010;
    localparam logic [SRC_W-1:0] SRC_LO    = 3'b011;
    localparam logic [SRC_W-1:0] SRC_SHIFT = 3'b100;
    localparam logic [SRC_W-1:0] SRC_LT32  = 3'b101;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2
    } wb_state_e;

    // Codes 110 and 111 have no producer behind them.
    function automatic logic src_is_legal(input logic [SRC_W-1:0] src);
        return (src <= SRC_LT32);
    endfunction

    // Sources whose result is already valid when the request arrives.
    function automatic logic src_is_immediate(input logic [SRC_W-1:0] src);
        return (src == SRC_ULA) || (src == SRC_LS) || (src == SRC_LT32);
    endfunction

    // The shifter completes on ShiftDone; HI/LO complete on MultDivDone.
    function automatic logic src_uses_shift(input logic [SRC_W-1:0] src);
        return (src == SRC_SHIFT);
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter -- counts WAIT cycles without a done and flags the
// final allowed cycle. Only instantiated when WB_CTRL_TIMEOUT_EN is defined.
module wb_timeout_counter #(
    parameter int LIMIT = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count;

    // Count up from zero; hold once the last allowed value is reached.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + W'(1);
        end
    end

    // Combinational flag: the current WAIT cycle is the last one allowed.
    assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl -- writeback controller. Accepts one request at a time, waits for
// the multiply/divide unit or the shifter when needed, then issues a single
// register-file write. Define WB_CTRL_TIMEOUT_EN to abort WAIT after
// TIMEOUT_CYCLES cycles without a done (Error pulse, no write).
module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [SRC_W-1:0]  ReqSrc,
    input  logic [DEST_W-1:0] ReqDest,
    input  logic              MultDivDone,
    input  logic              ShiftDone,
    output logic [SRC_W-1:0]  WriteData,
    output logic [DEST_W-1:0] RegDest,
    output logic              RegWrite,
    output logic              Error
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    wb_state_e state_q, state_d;
    logic      err_d;
    logic      accept;
    logic      wait_done;
    logic      timeout_hit;

    assign ReqReady = (state_q == ST_IDLE);
    assign accept   = ReqValid && ReqReady;

    // The captured source selects which done input ends the wait.
    assign wait_done = src_uses_shift(WriteData) ? ShiftDone : MultDivDone;

    // Register 0 is hard-wired, so the write slot is spent without a strobe.
    assign RegWrite = (state_q == ST_WRITE) && (RegDest != '0);

`ifdef WB_CTRL_TIMEOUT_EN
    logic timeout_last;

    wb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept && (state_d == ST_WAIT)),
        .inc     ((state_q == ST_WAIT) && !wait_done),
        .expired (timeout_last)
    );

    assign timeout_hit = (state_q == ST_WAIT) && !wait_done && timeout_last;
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and error decision for the request sequence.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!src_is_legal(ReqSrc)) begin
                        err_d = 1'b1;
                    end else if (src_is_immediate(ReqSrc)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A done in the final allowed cycle still wins over the timeout.
                if (wait_done) begin
                    state_d = ST_WRITE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured request fields and the registered Error pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q   <= ST_IDLE;
            WriteData <= '0;
            RegDest   <= '0;
            Error     <= 1'b0;
        end else begin
            state_q <= state_d;
            Error   <= err_d;
            if (accept) begin
                WriteData <= ReqSrc;
                RegDest   <= ReqDest;
            end
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl -- self-checking bench for wb_ctrl: directed scenarios with
// literal expectations plus a randomized run compared every cycle against a
// transaction-level model. Define WB_CTRL_TIMEOUT_EN to run the timeout cases.
module tb_wb_ctrl;

`ifdef WB_CTRL_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 40;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       ReqValid;
    logic       ReqReady;
    logic [2:0] ReqSrc;
    logic [4:0] ReqDest;
    logic       MultDivDone;
    logic       ShiftDone;
    logic [2:0] WriteData;
    logic [4:0] RegDest;
    logic       RegWrite;
    logic       Error;

    int n_tests = 0;
    int n_fail  = 0;

    wb_ctrl #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqSrc      (ReqSrc),
        .ReqDest     (ReqDest),
        .MultDivDone (MultDivDone),
        .ShiftDone   (ShiftDone),
        .WriteData   (WriteData),
        .RegDest     (RegDest),
        .RegWrite    (RegWrite),
        .Error       (Error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: the request is either being offered to the
    // block (ready), parked on a producer (waiting, with a cycle count), or
    // owns the single write slot. Expected outputs are read from it.
    // ------------------------------------------------------------------
    bit       cmp_en = 1'b0;
    bit       m_ready, m_write, m_wait, m_shift, m_err;
    bit [2:0] m_wd;
    bit [4:0] m_rd;
    int       m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            cmp_en  <= 1'b1;
            m_ready <= 1'b1;
            m_write <= 1'b0;
            m_wait  <= 1'b0;
            m_shift <= 1'b0;
            m_err   <= 1'b0;
            m_wd    <= '0;
            m_rd    <= '0;
            m_cnt   <= 0;
        end else begin
            m_err <= 1'b0;
            if (m_ready) begin
                if (ReqValid) begin
                    m_wd <= ReqSrc;
                    m_rd <= ReqDest;
                    if (ReqSrc >= 3'd6) begin
                        m_err <= 1'b1;
                    end else if (ReqSrc inside {3'd2, 3'd3, 3'd4}) begin
                        m_ready <= 1'b0;
                        m_wait  <= 1'b1;
                        m_shift <= (ReqSrc == 3'd4);
                        m_cnt   <= 0;
                    end else begin
                        m_ready <= 1'b0;
                        m_write <= 1'b1;
                    end
                end
            end else if (m_wait) begin
                if (m_shift ? ShiftDone : MultDivDone) begin
                    m_wait  <= 1'b0;
                    m_write <= 1'b1;
                end else if (TO_EN && (m_cnt == TO - 1)) begin
                    m_wait  <= 1'b0;
                    m_ready <= 1'b1;
                    m_err   <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                m_write <= 1'b0;
                m_ready <= 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_ReqReady",  32'(ReqReady),  32'(m_ready));
            check("m_RegWrite",  32'(RegWrite),  32'(m_write && (m_rd != 5'd0)));
            check("m_Error",     32'(Error),     32'(m_err));
            check("m_WriteData", 32'(WriteData), 32'(m_wd));
            check("m_RegDest",   32'(RegDest),   32'(m_rd));
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [4:0] d);
        ReqValid = v;
        ReqSrc   = s;
        ReqDest  = d;
    endtask

    initial begin
        reset       = 1'b1;
        MultDivDone = 1'b0;
        ShiftDone   = 1'b0;
        drive(1'b0, 3'd0, 5'd0);

        // Two reset cycles, then release.
        repeat (2) @(posedge clk);
        next_cycle();
        check("rst_ReqReady",  32'(ReqReady),  32'd1);
        check("rst_WriteData", 32'(WriteData), 32'd0);
        check("rst_RegDest",   32'(RegDest),   32'd0);
        check("rst_RegWrite",  32'(RegWrite),  32'd0);
        check("rst_Error",     32'(Error),     32'd0);
        reset = 1'b0;
        next_cycle();
        check("rel_ReqReady", 32'(ReqReady), 32'd1);

        // Immediate source: write at T+1, ready again at T+2.
        drive(1'b1, 3'd0, 5'd8);
        next_cycle();
        drive(1'b0, 3'd0, 5'd0);
        check("ula_RegWrite",  32'(RegWrite),  32'd1);
        check("ula_RegDest",   32'(RegDest),   32'd8);
        check("ula_WriteData", 32'(WriteData), 32'd0);
        check("ula_busy",      32'(ReqReady),  32'd0);
        next_cycle();
        check("ula_wr_once",   32'(RegWrite),  32'd0);
        check("ula_ready",     32'(ReqReady),  32'd1);

        // HI source: done in the accept cycle is ignored, done at T+5 writes at T+6.
        drive(1'b1, 3'd2, 5'd3);
        MultDivDone = 1'b1;
        next_cycle();
        drive(1'b0, 3'd0, 5'd0);
        MultDivDone = 1'b0;
        check("hi_wait_ready", 32'(ReqReady), 32'd0);
        for (int t = 2; t <= 5; t++) begin
            next_cycle();
            check("hi_no_early_wr", 32'(RegWrite), 32'd0);
            if (t == 5) MultDivDone = 1'b1;
        end
        next_cycle();
        MultDivDone = 1'b0;
        check("hi_RegWrite",  32'(RegWrite),  32'd1);
        check("hi_RegDest",   32'(RegDest),   32'd3);
        check("hi_WriteData", 32'(WriteData), 32'd2);
        next_cycle();
        check("hi_wr_once", 32'(RegWrite), 32'd0);
        check("hi_ready",   32'(ReqReady), 32'd1);

        // Illegal source: one Error pulse, no write, stays ready.
        drive(1'b1, 3'd7, 5'd9);
        next_cycle();
        drive(1'b0, 3'd0, 5'd0);
        check("ill_Error",    32'(Error),    32'd1);
        check("ill_RegWrite", 32'(RegWrite), 32'd0);
        check("ill_ready",    32'(ReqReady), 32'd1);
        next_cycle();
        check("ill_err_once", 32'(Error),    32'd0);
        check("ill_ready2",   32'(ReqReady), 32'd1);

        // Destination 0: sequences through the write slot without a strobe.
        drive(1'b1, 3'd0, 5'd0);
        next_cycle();
        drive(1'b0, 3'd0, 5'd0);
        check("r0_RegWrite", 32'(RegWrite), 32'd0);
        check("r0_Error",    32'(Error),    32'd0);
        check("r0_busy",     32'(ReqReady), 32'd0);
        next_cycle();
        check("r0_ready",    32'(ReqReady), 32'd1);

        // Reset in the second WAIT cycle of an HI request discards it.
        drive(1'b1, 3'd2, 5'd5);
        next_cycle();
        drive(1'b0, 3'd0, 5'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset       = 1'b0;
        MultDivDone = 1'b1;
        check("rw_ready",   32'(ReqReady), 32'd1);
        check("rw_RegDest", 32'(RegDest),  32'd0);
        next_cycle();
        MultDivDone = 1'b0;
        check("rw_RegWrite", 32'(RegWrite), 32'd0);
        check("rw_idle",     32'(ReqReady), 32'd1);
        check("rw_Error",    32'(Error),    32'd0);

`ifdef WB_CTRL_TIMEOUT_EN
        // Shift never completes: Error in the cycle after the 4th WAIT cycle.
        drive(1'b1, 3'd4, 5'd6);
        next_cycle();
        drive(1'b0, 3'd0, 5'd0);
        for (int w = 1; w <= 4; w++) begin
            check("to_waiting", 32'(ReqReady), 32'd0);
            check("to_no_err",  32'(Error),    32'd0);
            next_cycle();
        end
        check("to_Error",    32'(Error),    32'd1);
        check("to_idle",     32'(ReqReady), 32'd1);
        check("to_RegWrite", 32'(RegWrite), 32'd0);
        next_cycle();
        check("to_err_once", 32'(Error), 32'd0);

        // Done in the final allowed cycle wins over the timeout.
        drive(1'b1, 3'd4, 5'd6);
        next_cycle();
        drive(1'b0, 3'd0, 5'd0);
        for (int w = 1; w <= 4; w++) begin
            if (w == 4) ShiftDone = 1'b1;
            next_cycle();
        end
        ShiftDone = 1'b0;
        check("tl_RegWrite", 32'(RegWrite), 32'd1);
        check("tl_Error",    32'(Error),    32'd0);
        next_cycle();
        check("tl_ready", 32'(ReqReady), 32'd1);
`else
        // Without the timeout, WAIT persists until the done arrives.
        drive(1'b1, 3'd4, 5'd6);
        next_cycle();
        drive(1'b0, 3'd0, 5'd0);
        for (int w = 0; w < 60; w++) begin
            check("lw_waiting", 32'(ReqReady), 32'd0);
            check("lw_no_err",  32'(Error),    32'd0);
            next_cycle();
        end
        ShiftDone = 1'b1;
        next_cycle();
        ShiftDone = 1'b0;
        check("lw_RegWrite", 32'(RegWrite), 32'd1);
        check("lw_RegDest",  32'(RegDest),  32'd6);
        next_cycle();
`endif

        // Randomized traffic, checked each cycle against the model.
        for (int c = 0; c < 2000; c++) begin
            reset       = ($urandom_range(0, 59) == 0);
            ReqValid    = $urandom_range(0, 1) == 1;
            ReqSrc      = 3'($urandom_range(0, 7));
            ReqDest     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            MultDivDone = ($urandom_range(0, 5) == 0);
            ShiftDone   = ($urandom_range(0, 5) == 0);
            next_cycle();
        end
        reset       = 1'b0;
        MultDivDone = 1'b0;
        ShiftDone   = 1'b0;
        drive(1'b0, 3'd0, 5'd0);
        repeat (3) next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 40: maximum WAIT cycles before abort.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ReqValid, input, 1 bit: a writeback request is present.
REQ-005 The block SHALL have port ReqReady, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port ReqSrc, input, 3 bits: source code (000 ULA, 001 LS, 010 HI, 011 LO, 100 Shift, 101 LT32).
REQ-007 The block SHALL have port ReqDest, input, 5 bits: destination register index.
REQ-008 The block SHALL have port MultDivDone, input, 1 bit: HI/LO results are valid.
REQ-009 The block SHALL have port ShiftDone, input, 1 bit: the shifter result is valid.
REQ-010 The block SHALL have port WriteData, output, 3 bits: registered select to the writeback mux.
REQ-011 The block SHALL have port RegDest, output, 5 bits: registered register-file write address.
REQ-012 The block SHALL have port RegWrite, output, 1 bit: register-file write enable.
REQ-013 The block SHALL have port Error, output, 1 bit: one-cycle pulse on an illegal source or a timeout.

Function
REQ-014 The block SHALL use the states IDLE, WAIT and WRITE.
REQ-015 ReqReady SHALL be high exactly when the state is IDLE.
REQ-016 A request SHALL be accepted when ReqValid and ReqReady are both high; on acceptance WriteData<=ReqSrc and RegDest<=ReqDest.
REQ-017 On acceptance, ReqSrc 000/001/101 SHALL go to WRITE, 010/011 to WAIT on MultDivDone, and 100 to WAIT on ShiftDone.
REQ-018 Done inputs SHALL be sampled only in WAIT; a done asserted in the acceptance cycle SHALL be ignored.
REQ-019 In WAIT, when the selected done input is high, the next state SHALL be WRITE.
REQ-020 RegWrite SHALL be high for exactly the one cycle spent in WRITE; the next state SHALL be IDLE.
REQ-021 Latency: for an accept at cycle T on an immediate source, RegWrite SHALL be high at T+1 and ReqReady high at T+2.
REQ-022 Latency: for a done seen in WAIT at cycle T+k, RegWrite SHALL be high at T+k+1.
REQ-023 If ReqDest is 0, the block SHALL sequence normally with RegWrite held low in WRITE and no Error.
REQ-024 On acceptance of ReqSrc 110/111, the block SHALL remain in IDLE, pulse Error for one cycle and never assert RegWrite.
REQ-025 WriteData and RegDest SHALL hold their values outside acceptance cycles.

Reset
REQ-026 When reset is high at a clock edge, the next state SHALL be IDLE with WriteData=000, RegDest=0, RegWrite=0, Error=0 and the timeout counter cleared.
REQ-027 Reset SHALL take priority over all other inputs, including mid-WAIT and during WRITE; an interrupted request SHALL be discarded without a write.
REQ-028 ReqReady SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-029 With WB_CTRL_TIMEOUT_EN defined, a WAIT counter SHALL clear on entry to WAIT and increment every WAIT cycle without done.
REQ-030 With WB_CTRL_TIMEOUT_EN defined, a WAIT cycle with counter = TIMEOUT_CYCLES-1 and no done SHALL pulse Error next cycle and return to IDLE without a write.
REQ-031 With WB_CTRL_TIMEOUT_EN defined, a done arriving in that same final cycle SHALL win: WRITE and no Error.
REQ-032 Without WB_CTRL_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL last indefinitely, and Error SHALL pulse only for illegal sources.

Structure
REQ-033 Package wb_ctrl_pkg SHALL hold the source-code constants (SRC_ULA..SRC_LT32) and the state encoding.
REQ-034 The timeout counter SHALL be sub-module wb_timeout_counter, instantiated only under WB_CTRL_TIMEOUT_EN.

Verification
REQ-035 The bench SHALL apply reset for 2 cycles, then release -> all outputs at reset values and ReqReady=1.
REQ-036 The bench SHALL request ReqSrc=000, ReqDest=8 at T -> RegWrite=1, RegDest=8, WriteData=000 at T+1 only; ReqReady=1 at T+2.
REQ-037 The bench SHALL request ReqSrc=010, ReqDest=3 with MultDivDone high at T+5 -> RegWrite at T+6 only; a MultDivDone pulse at T is ignored.
REQ-038 The bench SHALL request ReqSrc=111 -> Error for one cycle, no RegWrite, ReqReady stays 1; ReqSrc=000 with ReqDest=0 -> no RegWrite and no Error.
REQ-039 With WB_CTRL_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, the bench SHALL request ReqSrc=100 with ShiftDone never high -> Error one cycle after the 4th WAIT cycle, then IDLE.
REQ-040 With WB_CTRL_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, the bench SHALL raise ShiftDone in the 4th WAIT cycle -> a write and no Error.
REQ-041 The bench SHALL assert reset in the 2nd WAIT cycle of an HI request, then raise MultDivDone -> no RegWrite, state IDLE.
